axi_slave_mem: RTL and testbench
================================

Name: axi_slave_mem

Overview:
- Parametrised AXI4 memory slave; successor to the interface-only slave stubs on the interconnect.
- Fully services write and read bursts against an internal word-addressed RAM window at BASE_ADDR.
- Supports FIXED, INCR and WRAP bursts, byte strobes, narrow transfers, IDs and OKAY/SLVERR responses.
- Allows one outstanding transaction per direction; the write and read paths run independently.

Parameters:
ADDR_WID, 32, address width
DATA_WID, 32, data width (8..1024, power of 2)
ID_WID, 2, AXI ID width
MEM_DEPTH, 1024, RAM depth in DATA_WID words
BASE_ADDR, 0, byte base address of window (aligned to window size)

Ports:
aclk  in  1  clock
areset  in  1  asynchronous active-high reset
awid  in  ID_WID  write ID
awaddr  in  ADDR_WID  write start address
awlen  in  8  beats-1
awsize  in  3  log2 bytes/beat
awburst  in  2  00 FIXED, 01 INCR, 10 WRAP
awvalid  in  1 / awready out 1  AW handshake
wdata  in  DATA_WID  write data
wstrb  in  DATA_WID/8  byte enables
wlast  in  1  final beat marker
wvalid  in  1 / wready  out 1  W handshake
bid  out  ID_WID / bresp out 2  write response
bvalid  out  1 / bready  in 1  B handshake
arid, araddr, arlen, arsize, arburst, arvalid  in  as AW  read address
arready  out  1  AR ready
rid  out  ID_WID / rdata out DATA_WID / rresp out 2 / rlast out 1  read beat
rvalid  out  1 / rready  in 1  R handshake

Behaviour:
Reset:
- areset is asynchronous, active-high.
- All FSMs go to IDLE. Every output is 0 except awready=1 and arready=1.
- RAM is not cleared.
- Reset mid-burst abandons the burst; beats already written remain written.

Address rules:
- Beat address update: FIXED holds; INCR adds 1<<size.
- WRAP: add 1<<size, wrap within a window of (len+1)<<size bytes, aligned to that window.
- RAM index = (addr-BASE_ADDR) >> log2(DATA_WID/8).
- In range iff BASE_ADDR <= addr < BASE_ADDR + MEM_DEPTH*DATA_WID/8.
- Illegal burst: size > log2(DATA_WID/8), WRAP with len not in {1,3,7,15}, or burst 11. It is fully handshaken, performs no RAM writes, and returns SLVERR (and rdata=0 on reads).

Write FSM (W_IDLE, W_DATA, W_RESP):
- W_IDLE: awready=1, wready=0. The AW handshake latches id/addr/len/size/burst, clears the beat counter and error flag, and moves to W_DATA.
- W_DATA: awready=0, wready=1.
  - Each W handshake writes the strobed bytes to RAM if the beat is in range; otherwise it sets the error flag.
  - wlast not matching (count==len) sets the error flag.
  - On the beat with count==len, move to W_RESP. The burst always ends by count, never by wlast.
- W_RESP: bvalid=1, bid=latched id, bresp=10 if error else 00. When bvalid&&bready, go to W_IDLE (awready=1 next cycle).

Read FSM (R_IDLE, R_DATA):
- R_IDLE: arready=1. The AR handshake latches fields and, on the same edge, loads the registered rdata/rresp/rlast/rid for beat 0 and sets rvalid. First data is visible 1 cycle after AR.
- R_DATA:
  - On rvalid&&rready with beats remaining, the next beat is loaded on the same edge (no bubbles).
  - Without rready, all R outputs hold stable.
  - On the final beat handshake: rvalid=0, go to R_IDLE.
  - Out-of-range beat: rdata=0, rresp=10. rlast=1 only on beat len.

Concurrency:
- Simultaneous RAM write and read-load of the same word on one edge: the read returns the old data.
- AW and AR accepted in the same cycle are both serviced.

Beat counter: 8 bits; len=255 gives 256 beats with no overflow.

Test Plan:
- INCR write awaddr=0x10, len=3, size=2, wdata 0xA0..0xA3, all strobes; then INCR read of the same -> bresp=00; rdata 0xA0,0xA1,0xA2,0xA3 with rlast on beat 3 only; rresp=00; first rvalid 1 cycle after AR.
- WRAP read araddr=0x18, len=3, size=2, RAM[i]=i -> word addresses 0x18,0x1C,0x10,0x14 -> rdata 6,7,4,5.
- Write wstrb=4'b0101, wdata=0xDEADBEEF over RAM word 0x11223344 -> readback 0x11AD33EF.
- Out-of-range and malformed bursts:
  - Write at BASE_ADDR+0x1000 (MEM_DEPTH=1024) -> bresp=10; RAM unchanged.
  - Read -> rdata=0, rresp=10.
  - wlast early on beat 1 of len=3 -> bresp=10, still 4 beats accepted.
- rready toggling 1,0,0,1 on a len=7 read; bready held low 5 cycles -> R outputs stable while stalled; bvalid held; awready stays 0 until B handshake.
- areset pulsed during beat 2 of a len=7 write -> outputs at reset values immediately, awready=arready=1; next burst completes with bresp=00; beats 0-1 readable.

Source files
------------

// File: rtl/axi_slave_mem.sv
// AXI4 memory slave: one outstanding burst per direction against a word-addressed RAM window.
// FIXED/INCR/WRAP bursts, byte strobes and SLVERR for out-of-window or malformed bursts.
module axi_slave_mem #(
  parameter int ADDR_WID = 32,
  parameter int DATA_WID = 32,
  parameter int ID_WID = 2,
  parameter int MEM_DEPTH = 1024,
  parameter logic [ADDR_WID-1:0] BASE_ADDR = '0
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [ID_WID-1:0]       awid,
  input  logic [ADDR_WID-1:0]     awaddr,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WID-1:0]     wdata,
  input  logic [DATA_WID/8-1:0]   wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [ID_WID-1:0]       bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ID_WID-1:0]       arid,
  input  logic [ADDR_WID-1:0]     araddr,
  input  logic [7:0]              arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [ID_WID-1:0]       rid,
  output logic [DATA_WID-1:0]     rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready
);

  localparam int STRB_WID = DATA_WID / 8;
  localparam int LOG2B = $clog2(STRB_WID);
  localparam int IDX_WID = $clog2(MEM_DEPTH);
  localparam logic [2:0] MAX_SIZE = 3'(LOG2B);
  localparam logic [ADDR_WID-1:0] ONE_A = {{(ADDR_WID-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WID-1:0] DEPTH_A = ADDR_WID'(MEM_DEPTH);

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wstate_t;
  typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_t;

  logic [DATA_WID-1:0] mem [MEM_DEPTH];

  function automatic logic illegal(input logic [7:0] len, input logic [2:0] size,
                                   input logic [1:0] burst);
    logic bad;
    bad = (size > MAX_SIZE) || (burst == 2'b11);
    if ((burst == 2'b10) && (len != 8'd1) && (len != 8'd3) && (len != 8'd7) && (len != 8'd15)) begin
      bad = 1'b1;
    end
    return bad;
  endfunction

  function automatic logic in_range(input logic [ADDR_WID-1:0] a);
    return (a >= BASE_ADDR) && (((a - BASE_ADDR) >> LOG2B) < DEPTH_A);
  endfunction

  function automatic logic [IDX_WID-1:0] mem_idx(input logic [ADDR_WID-1:0] a);
    return IDX_WID'((a - BASE_ADDR) >> LOG2B);
  endfunction

  // WRAP keeps the upper address bits and wraps the low bits inside a (len+1)<<size window.
  function automatic logic [ADDR_WID-1:0] next_addr(input logic [ADDR_WID-1:0] a,
                                                    input logic [7:0] len, input logic [2:0] size,
                                                    input logic [1:0] burst);
    logic [ADDR_WID-1:0] incr;
    logic [ADDR_WID-1:0] mask;
    logic [ADDR_WID-1:0] nxt;
    incr = ONE_A << size;
    mask = ((ADDR_WID'(len) + ONE_A) << size) - ONE_A;
    case (burst)
      2'b00:   nxt = a;
      2'b01:   nxt = a + incr;
      2'b10:   nxt = (a & ~mask) | ((a + incr) & mask);
      default: nxt = a;
    endcase
    return nxt;
  endfunction

  // ---------------- write path ----------------
  wstate_t w_state_r, w_next_s;
  logic [ID_WID-1:0]   w_id_r;
  logic [ADDR_WID-1:0] w_addr_r;
  logic [7:0]          w_len_r;
  logic [2:0]          w_size_r;
  logic [1:0]          w_burst_r;
  logic [7:0]          w_cnt_r;
  logic                w_err_r;
  logic                w_bad_r;
  logic                w_last_s;
  logic                w_beat_err_s;
  logic                w_we_s;

  // Write beat qualification
  always_comb begin
    w_last_s = (w_cnt_r == w_len_r);
    w_beat_err_s = w_bad_r || !in_range(w_addr_r) || (wlast != w_last_s);
    w_we_s = (w_state_r == W_DATA) && wvalid && !w_bad_r && in_range(w_addr_r);
  end

  // Write FSM next state
  always_comb begin
    w_next_s = w_state_r;
    case (w_state_r)
      W_IDLE:  if (awvalid) w_next_s = W_DATA; else w_next_s = W_IDLE;
      W_DATA:  if (wvalid && w_last_s) w_next_s = W_RESP; else w_next_s = W_DATA;
      W_RESP:  if (bready) w_next_s = W_IDLE; else w_next_s = W_RESP;
      default: w_next_s = W_IDLE;
    endcase
  end

  // Write FSM state, burst context and registered AW/W/B outputs
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      w_state_r <= W_IDLE;
      awready   <= 1'b1;
      wready    <= 1'b0;
      bvalid    <= 1'b0;
      bid       <= '0;
      bresp     <= 2'b00;
      w_id_r    <= '0;
      w_addr_r  <= '0;
      w_len_r   <= 8'd0;
      w_size_r  <= 3'd0;
      w_burst_r <= 2'b00;
      w_cnt_r   <= 8'd0;
      w_err_r   <= 1'b0;
      w_bad_r   <= 1'b0;
    end else begin
      w_state_r <= w_next_s;
      awready   <= (w_next_s == W_IDLE);
      wready    <= (w_next_s == W_DATA);
      bvalid    <= (w_next_s == W_RESP);
      case (w_state_r)
        W_IDLE: if (awvalid) begin
          w_id_r    <= awid;
          w_addr_r  <= awaddr;
          w_len_r   <= awlen;
          w_size_r  <= awsize;
          w_burst_r <= awburst;
          w_cnt_r   <= 8'd0;
          w_err_r   <= 1'b0;
          w_bad_r   <= illegal(awlen, awsize, awburst);
        end
        W_DATA: if (wvalid) begin
          w_cnt_r  <= w_cnt_r + 8'd1;
          w_addr_r <= next_addr(w_addr_r, w_len_r, w_size_r, w_burst_r);
          w_err_r  <= w_err_r | w_beat_err_s;
          if (w_last_s) begin
            bid   <= w_id_r;
            bresp <= (w_err_r || w_beat_err_s) ? 2'b10 : 2'b00;
          end
        end
        W_RESP: if (bready) begin
          bid   <= '0;
          bresp <= 2'b00;
        end
        default: ;
      endcase
    end
  end

  // RAM write port; contents intentionally survive reset
  always_ff @(posedge aclk) begin
    if (w_we_s) begin
      for (int b = 0; b < STRB_WID; b++) begin
        if (wstrb[b]) mem[mem_idx(w_addr_r)][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // ---------------- read path ----------------
  rstate_t r_state_r, r_next_s;
  logic [ADDR_WID-1:0] r_addr_r;
  logic [7:0]          r_len_r;
  logic [2:0]          r_size_r;
  logic [1:0]          r_burst_r;
  logic [7:0]          r_cnt_r;
  logic                r_bad_r;
  logic [ADDR_WID-1:0] r_beat_addr_s;
  logic                r_beat_ok_s;
  logic                r_beat_last_s;
  logic [DATA_WID-1:0] r_word_s;

  // Beat to load: beat 0 straight from AR, later beats from the burst context
  always_comb begin
    r_beat_addr_s = r_addr_r;
    r_beat_ok_s   = 1'b0;
    r_beat_last_s = 1'b0;
    r_word_s      = '0;
    if (r_state_r == R_IDLE) begin
      r_beat_addr_s = araddr;
      r_beat_ok_s   = !illegal(arlen, arsize, arburst) && in_range(araddr);
      r_beat_last_s = (arlen == 8'd0);
    end else begin
      r_beat_addr_s = r_addr_r;
      r_beat_ok_s   = !r_bad_r && in_range(r_addr_r);
      r_beat_last_s = (r_cnt_r == r_len_r);
    end
    if (r_beat_ok_s) r_word_s = mem[mem_idx(r_beat_addr_s)];
    else r_word_s = '0;
  end

  // Read FSM next state
  always_comb begin
    r_next_s = r_state_r;
    case (r_state_r)
      R_IDLE:  if (arvalid) r_next_s = R_DATA; else r_next_s = R_IDLE;
      R_DATA:  if (rready && rlast) r_next_s = R_IDLE; else r_next_s = R_DATA;
      default: r_next_s = R_IDLE;
    endcase
  end

  // Read FSM state, burst context and registered R beat
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state_r <= R_IDLE;
      arready   <= 1'b1;
      rvalid    <= 1'b0;
      rid       <= '0;
      rdata     <= '0;
      rresp     <= 2'b00;
      rlast     <= 1'b0;
      r_addr_r  <= '0;
      r_len_r   <= 8'd0;
      r_size_r  <= 3'd0;
      r_burst_r <= 2'b00;
      r_cnt_r   <= 8'd0;
      r_bad_r   <= 1'b0;
    end else begin
      r_state_r <= r_next_s;
      arready   <= (r_next_s == R_IDLE);
      case (r_state_r)
        R_IDLE: if (arvalid) begin
          r_addr_r  <= next_addr(araddr, arlen, arsize, arburst);
          r_len_r   <= arlen;
          r_size_r  <= arsize;
          r_burst_r <= arburst;
          r_cnt_r   <= 8'd1;
          r_bad_r   <= illegal(arlen, arsize, arburst);
          rid       <= arid;
          rvalid    <= 1'b1;
          rdata     <= r_word_s;
          rresp     <= r_beat_ok_s ? 2'b00 : 2'b10;
          rlast     <= r_beat_last_s;
        end
        R_DATA: if (rready) begin
          if (rlast) begin
            rvalid <= 1'b0;
            rlast  <= 1'b0;
            rdata  <= '0;
            rresp  <= 2'b00;
            rid    <= '0;
          end else begin
            r_addr_r <= next_addr(r_addr_r, r_len_r, r_size_r, r_burst_r);
            r_cnt_r  <= r_cnt_r + 8'd1;
            rdata    <= r_word_s;
            rresp    <= r_beat_ok_s ? 2'b00 : 2'b10;
            rlast    <= r_beat_last_s;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed bench for axi_slave_mem: reference RAM model plus a queue of expected R beats.
module tb_axi_slave_mem;

  logic        aclk = 1'b0;
  logic        areset;
  logic [1:0]  awid, arid, bid, rid, bresp, rresp, awburst, arburst;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;

  axi_slave_mem dut (
    .aclk(aclk), .areset(areset),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [31:0] d;
    logic [1:0]  r;
    logic        l;
    logic [1:0]  id;
  } rexp_t;

  rexp_t       sb[$];
  logic [31:0] model [1024];
  int          tests = 0;
  int          fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input logic [31:0] d0, input logic [3:0] strb, input int early,
                          input logic legal, input logic [1:0] eresp, input int bdelay,
                          input logic [1:0] id);
    int t;
    logic [31:0] a;
    awid = id; awaddr = addr; awlen = len; awsize = 3'd2; awburst = burst; awvalid = 1'b1;
    t = 0;
    while (!awready && t < 20) begin @(posedge aclk); #1; t++; end
    chk("aw_ready", awready, 1'b1);
    @(posedge aclk); #1;
    awvalid = 1'b0;
    a = addr;
    for (int i = 0; i <= int'(len); i++) begin
      wdata = d0 + i; wstrb = strb; wvalid = 1'b1;
      wlast = (early >= 0) ? (i == early) : (i == int'(len));
      t = 0;
      while (!wready && t < 20) begin @(posedge aclk); #1; t++; end
      chk("w_ready", wready, 1'b1);
      if (legal && a < 32'h1000) begin
        for (int b = 0; b < 4; b++) if (strb[b]) model[a[11:2]][b*8 +: 8] = wdata[b*8 +: 8];
      end
      @(posedge aclk); #1;
      if (burst == 2'b01) a = a + 32'd4;
    end
    wvalid = 1'b0; wlast = 1'b0;
    for (int c = 0; c < bdelay; c++) begin
      chk("b_hold", bvalid, 1'b1);
      chk("aw_blocked", awready, 1'b0);
      @(posedge aclk); #1;
    end
    bready = 1'b1;
    t = 0;
    while (!bvalid && t < 20) begin @(posedge aclk); #1; t++; end
    chk("bvalid", bvalid, 1'b1);
    chk("bid", bid, id);
    chk("bresp", bresp, eresp);
    @(posedge aclk); #1;
    bready = 1'b0;
    chk("b_done", bvalid, 1'b0);
    chk("aw_reopen", awready, 1'b1);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic legal, input logic stall,
                         input logic [1:0] id);
    int t, cyc, win;
    logic [31:0] base, ai;
    logic ok, held;
    logic [63:0] snap;
    rexp_t e;
    for (int i = 0; i <= int'(len); i++) begin
      if (burst == 2'b00) ai = addr;
      else if (burst == 2'b01) ai = addr + i * (1 << size);
      else begin
        win  = (int'(len) + 1) * (1 << size);
        base = addr - (addr % win);
        ai   = base + ((addr - base + i * (1 << size)) % win);
      end
      ok = legal && (ai < 32'h1000);
      e.d = ok ? model[ai[11:2]] : 32'h0;
      e.r = ok ? 2'b00 : 2'b10;
      e.l = (i == int'(len));
      e.id = id;
      sb.push_back(e);
    end
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    t = 0;
    while (!arready && t < 20) begin @(posedge aclk); #1; t++; end
    chk("ar_ready", arready, 1'b1);
    @(posedge aclk); #1;
    arvalid = 1'b0;
    chk("r_first", rvalid, 1'b1);
    cyc = 0;
    while (sb.size() > 0 && cyc < 200) begin
      rready = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      held = rvalid && !rready;
      snap = {26'h0, rvalid, rlast, rresp, rid, rdata};
      if (rvalid && rready) begin
        e = sb.pop_front();
        chk("rdata", rdata, e.d);
        chk("rresp", rresp, e.r);
        chk("rlast", rlast, e.l);
        chk("rid", rid, e.id);
      end
      @(posedge aclk); #1;
      if (held) chk("r_stall_hold", {26'h0, rvalid, rlast, rresp, rid, rdata}, snap);
      cyc++;
    end
    chk("r_drained", sb.size(), 0);
    rready = 1'b0;
    chk("r_end", rvalid, 1'b0);
    chk("ar_reopen", arready, 1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    areset = 1'b1;
    awid = 2'd0; awaddr = 32'h0; awlen = 8'd0; awsize = 3'd0; awburst = 2'b00; awvalid = 1'b0;
    wdata = 32'h0; wstrb = 4'h0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = 2'd0; araddr = 32'h0; arlen = 8'd0; arsize = 3'd0; arburst = 2'b00; arvalid = 1'b0;
    rready = 1'b0;
    repeat (3) @(posedge aclk);
    #1 areset = 1'b0;
    chk("rst_awready", awready, 1'b1);
    chk("rst_arready", arready, 1'b1);
    chk("rst_wready", wready, 1'b0);
    chk("rst_bvalid", bvalid, 1'b0);
    chk("rst_rvalid", rvalid, 1'b0);
    chk("rst_rout", {rlast, rresp, rid, rdata}, 64'h0);
    chk("rst_bout", {bresp, bid}, 64'h0);

    // INCR write then readback
    do_write(32'h10, 8'd3, 2'b01, 32'hA0, 4'hF, -1, 1'b1, 2'b00, 0, 2'd1);
    do_read(32'h10, 8'd3, 3'd2, 2'b01, 1'b1, 1'b0, 2'd1);

    // WRAP read over RAM[i]=i
    do_write(32'h10, 8'd3, 2'b01, 32'd4, 4'hF, -1, 1'b1, 2'b00, 0, 2'd0);
    do_read(32'h18, 8'd3, 3'd2, 2'b10, 1'b1, 1'b0, 2'd2);

    // Strobed merge
    do_write(32'h40, 8'd0, 2'b01, 32'h11223344, 4'hF, -1, 1'b1, 2'b00, 0, 2'd0);
    do_write(32'h40, 8'd0, 2'b01, 32'hDEADBEEF, 4'b0101, -1, 1'b1, 2'b00, 0, 2'd3);
    do_read(32'h40, 8'd0, 3'd2, 2'b01, 1'b1, 1'b0, 2'd0);

    // Out-of-window write must not alias onto low words
    do_write(32'h0, 8'd1, 2'b01, 32'h55AA0000, 4'hF, -1, 1'b1, 2'b00, 0, 2'd0);
    do_write(32'h1000, 8'd1, 2'b01, 32'h99, 4'hF, -1, 1'b1, 2'b10, 0, 2'd2);
    do_read(32'h0, 8'd1, 3'd2, 2'b01, 1'b1, 1'b0, 2'd0);
    do_read(32'h1000, 8'd1, 3'd2, 2'b01, 1'b1, 1'b0, 2'd3);

    // Malformed bursts
    do_write(32'h20, 8'd1, 2'b01, 32'h300, 4'hF, -1, 1'b1, 2'b00, 0, 2'd0);
    do_write(32'h20, 8'd1, 2'b11, 32'h77, 4'hF, -1, 1'b0, 2'b10, 0, 2'd1);
    do_read(32'h20, 8'd1, 3'd2, 2'b01, 1'b1, 1'b0, 2'd1);
    do_read(32'h10, 8'd2, 3'd2, 2'b10, 1'b0, 1'b0, 2'd2);
    do_read(32'h10, 8'd0, 3'd3, 2'b01, 1'b0, 1'b0, 2'd3);

    // Early wlast still runs to len
    do_write(32'h80, 8'd3, 2'b01, 32'hE0, 4'hF, 1, 1'b1, 2'b10, 0, 2'd0);

    // Back-pressure on B and R
    do_write(32'hC0, 8'd7, 2'b01, 32'hB0, 4'hF, -1, 1'b1, 2'b00, 5, 2'd1);
    do_read(32'hC0, 8'd7, 3'd2, 2'b01, 1'b1, 1'b1, 2'd2);

    // Reset in the middle of beat 2 of a len=7 write
    awid = 2'd0; awaddr = 32'h100; awlen = 8'd7; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
    t = 0;
    while (!awready && t < 20) begin @(posedge aclk); #1; t++; end
    chk("rst_aw_ready", awready, 1'b1);
    @(posedge aclk); #1;
    awvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wdata = 32'hC0 + i; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
      t = 0;
      while (!wready && t < 20) begin @(posedge aclk); #1; t++; end
      chk("rst_w_ready", wready, 1'b1);
      model[64 + i] = wdata;
      @(posedge aclk); #1;
    end
    wdata = 32'hC2;
    #2 areset = 1'b1;
    #1;
    chk("mid_rst_awready", awready, 1'b1);
    chk("mid_rst_arready", arready, 1'b1);
    chk("mid_rst_wready", wready, 1'b0);
    chk("mid_rst_bvalid", bvalid, 1'b0);
    chk("mid_rst_rvalid", rvalid, 1'b0);
    wvalid = 1'b0;
    @(posedge aclk); #1;
    areset = 1'b0;
    chk("post_rst_awready", awready, 1'b1);
    do_write(32'h200, 8'd1, 2'b01, 32'hF0, 4'hF, -1, 1'b1, 2'b00, 0, 2'd2);
    do_read(32'h100, 8'd1, 3'd2, 2'b01, 1'b1, 1'b0, 2'd1);
    do_read(32'h200, 8'd1, 3'd2, 2'b01, 1'b1, 1'b0, 2'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
